// File: rtl/drive_cmd_uart_tx.sv
// Drive-command UART transmitter: encodes w/a/s/d into a code byte, sends 8N1 on change/keepalive.
// Build with DRIVE_TX_PARITY_EN defined for 8E1 framing.
module drive_cmd_uart_tx #(
  parameter int CLK_FREQ     = 50000000,
  parameter int BAUD         = 115200,
  parameter int KEEPALIVE_MS = 100
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       cmd_w,
  input  logic       cmd_a,
  input  logic       cmd_s,
  input  logic       cmd_d,
  output logic       tx,
  output logic       busy,
  output logic       sent_pulse,
  output logic [7:0] last_code
);

  localparam int DIV = CLK_FREQ / BAUD;
  localparam int BW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [BW-1:0] BMAX = BW'(DIV - 1);

  localparam int KA = KEEPALIVE_MS * (CLK_FREQ / 1000);
  localparam int KW = (KA > 1) ? $clog2(KA) : 1;

`ifdef DRIVE_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE, START, DATA, STOP
  } state_t;
`endif

  state_t          state;
  state_t          state_nxt;
  logic [BW-1:0]   bcnt;
  logic [2:0]      bitcnt;
  logic [7:0]      shreg;
  logic            force_q;
  logic            en_q;
  logic            ka_exp;

  logic            go_w;
  logic            go_a;
  logic            go_s;
  logic            go_d;
  logic [7:0]      code;
  logic            en_rise;
  logic            pending;
  logic            bit_end;
  logic            start_frame;

  // Opposing requests cancel each other out.
  assign go_w = cmd_w & ~cmd_s;
  assign go_s = cmd_s & ~cmd_w;
  assign go_a = cmd_a & ~cmd_d;
  assign go_d = cmd_d & ~cmd_a;
  assign code = {4'b0, go_d, go_s, go_a, go_w};

  assign en_rise     = enable & ~en_q;
  assign pending     = enable &
                       (force_q | en_rise |
                        (code != last_code) | ka_exp);
  assign bit_end     = (bcnt == BMAX);
  assign start_frame = (state == IDLE) & pending;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (pending) state_nxt = START;
      START: if (bit_end) state_nxt = DATA;
`ifdef DRIVE_TX_PARITY_EN
      DATA:   if (bit_end && bitcnt == 3'd7)
                state_nxt = PARITY;
      PARITY: if (bit_end) state_nxt = STOP;
`else
      DATA:  if (bit_end && bitcnt == 3'd7)
               state_nxt = STOP;
`endif
      STOP:  if (bit_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    tx         = 1'b1;
    busy       = 1'b1;
    sent_pulse = 1'b0;
    unique case (state)
      IDLE:   busy = 1'b0;
      START:  tx = 1'b0;
      DATA:   tx = shreg[0];
`ifdef DRIVE_TX_PARITY_EN
      PARITY: tx = ^last_code;
`endif
      STOP:   sent_pulse = bit_end;
      default: busy = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcnt      <= '0;
      bitcnt    <= 3'd0;
      shreg     <= 8'h00;
      last_code <= 8'h00;
    end else if (start_frame) begin
      bcnt      <= '0;
      bitcnt    <= 3'd0;
      shreg     <= code;
      last_code <= code;
    end else if (state != IDLE) begin
      if (bit_end) begin
        bcnt <= '0;
        if (state == DATA) begin
          shreg  <= {1'b0, shreg[7:1]};
          bitcnt <= bitcnt + 3'd1;
        end
      end else begin
        bcnt <= bcnt + BW'(1);
      end
    end
  end

  // A rising enable must win over the end-of-frame clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      force_q <= 1'b1;
      en_q    <= 1'b0;
    end else begin
      en_q <= enable;
      if (en_rise)
        force_q <= 1'b1;
      else if (state == STOP && bit_end)
        force_q <= 1'b0;
    end
  end

  generate
    if (KA > 0) begin : g_ka
      localparam logic [KW-1:0] KMAX = KW'(KA - 1);
      logic [KW-1:0] ka_cnt;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          ka_cnt <= '0;
        else if (start_frame)
          ka_cnt <= '0;
        else if (ka_cnt != KMAX)
          ka_cnt <= ka_cnt + KW'(1);
      end
      assign ka_exp = (ka_cnt == KMAX);
    end else begin : g_no_ka
      assign ka_exp = 1'b0;
    end
  endgenerate

endmodule
